// File: rtl/motoro3_step_sequencer.sv
// Step/timebase controller for the 3-phase motor PWM datapath: per-step counter,
// step index, First/Last strobes and the PWM gate, with start, orderly stop and fault abort.
module motoro3_step_sequencer #(
   parameter int unsigned STEP_MAX = 11,
   parameter int unsigned LEN_MIN  = 4
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic        runEn,
   input  logic        faultIn,
   input  logic [24:0] m3r_stepLen,
   output logic        pwmActive1,
   output logic [3:0]  sgStep,
   output logic [24:0] m3cnt,
   output logic        m3cntFirst2,
   output logic        m3cntFirst1,
   output logic        m3cntLast2,
   output logic        m3cntLast1,
   output logic        cycleDone,
   output logic        busy,
   output logic        faultFlag
);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      RUN,
      STOP,
      FAULT
   } stateT;

   localparam logic [3:0]  STEP_LAST = 4'(STEP_MAX);
   localparam logic [3:0]  STEP_NONE = 4'd15;
   localparam logic [24:0] LEN_FLOOR = 25'(LEN_MIN);

   stateT       state;
   stateT       stateNext;
   logic [24:0] lenQ;
   logic [24:0] lenNext;
   logic [24:0] cntNext;
   logic [3:0]  stepNext;
   logic        faultNext;
   logic [24:0] lenClamped;
   logic [24:0] advCnt;
   logic [3:0]  advStep;
   logic [24:0] advLen;
   logic        stepEnd;
   logic        cycleEnd;
   logic        counting;

   // Requested lengths below the floor are raised to it so the four strobes stay distinct.
   assign lenClamped = (m3r_stepLen < LEN_FLOOR) ? LEN_FLOOR : m3r_stepLen;
   assign stepEnd    = (m3cnt == lenQ - 25'd1);
   assign cycleEnd   = stepEnd && (sgStep == STEP_LAST);
   assign counting   = (state == RUN) || (state == STOP);

   // A step boundary restarts the count and picks up the newest length request.
   assign advCnt  = stepEnd ? 25'd0 : m3cnt + 25'd1;
   assign advStep = stepEnd ? ((sgStep == STEP_LAST) ? 4'd0 : sgStep + 4'd1) : sgStep;
   assign advLen  = stepEnd ? lenClamped : lenQ;

   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         state     <= IDLE;
         m3cnt     <= 25'd0;
         sgStep    <= STEP_NONE;
         lenQ      <= LEN_FLOOR;
         faultFlag <= 1'b0;
      end else begin
         state     <= stateNext;
         m3cnt     <= cntNext;
         sgStep    <= stepNext;
         lenQ      <= lenNext;
         faultFlag <= faultNext;
      end
   end

   // Fault is checked first in every active state so it beats step boundaries and runEn.
   always_comb begin
      stateNext = state;
      cntNext   = m3cnt;
      stepNext  = sgStep;
      lenNext   = lenQ;
      faultNext = faultFlag;
      case (state)
         IDLE: begin
            cntNext  = 25'd0;
            stepNext = STEP_NONE;
            if (runEn && !faultIn && !faultFlag) begin
               stateNext = ARM;
            end
         end
         ARM: begin
            cntNext = 25'd0;
            if (faultIn) begin
               stateNext = FAULT;
               stepNext  = STEP_NONE;
               faultNext = 1'b1;
            end else begin
               stateNext = RUN;
               stepNext  = 4'd0;
               lenNext   = lenClamped;
            end
         end
         RUN: begin
            if (faultIn) begin
               stateNext = FAULT;
               cntNext   = 25'd0;
               stepNext  = STEP_NONE;
               faultNext = 1'b1;
            end else begin
               cntNext  = advCnt;
               stepNext = advStep;
               lenNext  = advLen;
               if (!runEn) begin
                  stateNext = STOP;
               end
            end
         end
         STOP: begin
            if (faultIn) begin
               stateNext = FAULT;
               cntNext   = 25'd0;
               stepNext  = STEP_NONE;
               faultNext = 1'b1;
            end else if (!runEn && cycleEnd) begin
               stateNext = IDLE;
               cntNext   = 25'd0;
               stepNext  = STEP_NONE;
            end else begin
               cntNext  = advCnt;
               stepNext = advStep;
               lenNext  = advLen;
               if (runEn) begin
                  stateNext = RUN;
               end
            end
         end
         FAULT: begin
            cntNext   = 25'd0;
            stepNext  = STEP_NONE;
            faultNext = 1'b1;
            if (!faultIn && !runEn) begin
               stateNext = IDLE;
               faultNext = 1'b0;
            end
         end
         default: begin
            stateNext = IDLE;
            cntNext   = 25'd0;
            stepNext  = STEP_NONE;
         end
      endcase
   end

   assign pwmActive1  = counting;
   assign busy        = (state == ARM) || counting;
   assign m3cntFirst2 = counting && (m3cnt == 25'd0);
   assign m3cntFirst1 = counting && (m3cnt == 25'd1);
   assign m3cntLast2  = counting && (m3cnt == lenQ - 25'd2);
   assign m3cntLast1  = counting && stepEnd;
   assign cycleDone   = counting && cycleEnd;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Self-checking bench for motoro3_step_sequencer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_motoro3_step_sequencer;

   localparam int STEP_MAX = 11;

   localparam logic [2:0] M_IDLE  = 3'd0;
   localparam logic [2:0] M_ARM   = 3'd1;
   localparam logic [2:0] M_RUN   = 3'd2;
   localparam logic [2:0] M_DRAIN = 3'd3;
   localparam logic [2:0] M_FAULT = 3'd4;

   typedef struct packed {
      logic [2:0]  mode;
      logic [3:0]  stepIdx;
      logic [24:0] curLen;
      logic [24:0] remaining;
      logic        flag;
   } modelT;

   logic        clk;
   logic        nRst;
   logic        runEn;
   logic        faultIn;
   logic [24:0] m3r_stepLen;
   logic        pwmActive1;
   logic [3:0]  sgStep;
   logic [24:0] m3cnt;
   logic        m3cntFirst2;
   logic        m3cntFirst1;
   logic        m3cntLast2;
   logic        m3cntLast1;
   logic        cycleDone;
   logic        busy;
   logic        faultFlag;

   int    errCount = 0;
   int    checkCount = 0;
   bit    checkEn = 0;
   modelT mdl;

   motoro3_step_sequencer dut (
      .clk         (clk),
      .nRst        (nRst),
      .runEn       (runEn),
      .faultIn     (faultIn),
      .m3r_stepLen (m3r_stepLen),
      .pwmActive1  (pwmActive1),
      .sgStep      (sgStep),
      .m3cnt       (m3cnt),
      .m3cntFirst2 (m3cntFirst2),
      .m3cntFirst1 (m3cntFirst1),
      .m3cntLast2  (m3cntLast2),
      .m3cntLast1  (m3cntLast1),
      .cycleDone   (cycleDone),
      .busy        (busy),
      .faultFlag   (faultFlag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic modelT resetModel();
      modelT m;
      m.mode      = M_IDLE;
      m.stepIdx   = 4'd0;
      m.curLen    = 25'd4;
      m.remaining = 25'd4;
      m.flag      = 1'b0;
      return m;
   endfunction

   // The model tracks clocks remaining in the step rather than an up-counter.
   function automatic modelT modelStep(modelT m, logic r, logic f, logic [24:0] req);
      modelT       n;
      logic [24:0] cl;
      n  = m;
      cl = (req < 25'd4) ? 25'd4 : req;
      case (m.mode)
         M_IDLE: if (r && !f && !m.flag) n.mode = M_ARM;
         M_ARM: begin
            if (f) begin
               n.mode = M_FAULT;
               n.flag = 1'b1;
            end else begin
               n.mode      = M_RUN;
               n.stepIdx   = 4'd0;
               n.curLen    = cl;
               n.remaining = cl;
            end
         end
         M_RUN, M_DRAIN: begin
            if (f) begin
               n.mode = M_FAULT;
               n.flag = 1'b1;
            end else if (m.mode == M_DRAIN && !r && m.remaining == 25'd1
                         && int'(m.stepIdx) == STEP_MAX) begin
               n.mode = M_IDLE;
            end else begin
               if (m.remaining == 25'd1) begin
                  n.stepIdx   = (int'(m.stepIdx) == STEP_MAX) ? 4'd0 : m.stepIdx + 4'd1;
                  n.curLen    = cl;
                  n.remaining = cl;
               end else begin
                  n.remaining = m.remaining - 25'd1;
               end
               n.mode = r ? M_RUN : M_DRAIN;
            end
         end
         M_FAULT: begin
            if (!f && !r) begin
               n.mode = M_IDLE;
               n.flag = 1'b0;
            end
         end
         default: n = resetModel();
      endcase
      return n;
   endfunction

   always @(negedge clk or negedge nRst) begin
      if (!nRst) mdl <= resetModel();
      else       mdl <= modelStep(mdl, runEn, faultIn, m3r_stepLen);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkModel();
      logic        active;
      logic [24:0] cnt;
      active = (mdl.mode == M_RUN) || (mdl.mode == M_DRAIN);
      cnt    = active ? mdl.curLen - mdl.remaining : 25'd0;
      checkOutput("pwmActive1", 32'(pwmActive1), 32'(active));
      checkOutput("sgStep", 32'(sgStep), active ? 32'(mdl.stepIdx) : 32'd15);
      checkOutput("m3cnt", 32'(m3cnt), 32'(cnt));
      checkOutput("first2", 32'(m3cntFirst2), 32'(active && cnt == 25'd0));
      checkOutput("first1", 32'(m3cntFirst1), 32'(active && cnt == 25'd1));
      checkOutput("last2", 32'(m3cntLast2), 32'(active && mdl.remaining == 25'd2));
      checkOutput("last1", 32'(m3cntLast1), 32'(active && mdl.remaining == 25'd1));
      checkOutput("cycleDone", 32'(cycleDone),
                  32'(active && mdl.remaining == 25'd1 && int'(mdl.stepIdx) == STEP_MAX));
      checkOutput("busy", 32'(busy), 32'(active || mdl.mode == M_ARM));
      checkOutput("faultFlag", 32'(faultFlag), 32'(mdl.flag));
   endtask

   always @(posedge clk) begin
      if (checkEn) checkModel();
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic r, input logic f, input logic [24:0] len);
      runEn       = r;
      faultIn     = f;
      m3r_stepLen = len;
   endtask

   initial begin
      int cdCount;
      int cdIdx;
      int f1Count;
      int l2Count;
      int pwmLow;

      nRst = 1'b0;
      applyStimulus(1'b0, 1'b0, 25'd10);
      repeat (3) tick();
      checkEn = 1;
      checkOutput("resetStep", 32'(sgStep), 32'd15);
      checkOutput("resetPwm", 32'(pwmActive1), 32'd0);
      checkOutput("resetFlag", 32'(faultFlag), 32'd0);
      nRst = 1'b1;
      tick();
      checkOutput("idleBusy", 32'(busy), 32'd0);

      // Start with 10-clock steps: one ARM clock, then a 120-clock cycle.
      applyStimulus(1'b1, 1'b0, 25'd10);
      tick();
      checkOutput("armBusy", 32'(busy), 32'd1);
      checkOutput("armPwm", 32'(pwmActive1), 32'd0);
      checkOutput("armStep", 32'(sgStep), 32'd15);
      tick();
      checkOutput("runPwm", 32'(pwmActive1), 32'd1);
      checkOutput("runStep0", 32'(sgStep), 32'd0);
      checkOutput("runFirst2", 32'(m3cntFirst2), 32'd1);
      cdCount = 0; cdIdx = -1; f1Count = 0; l2Count = 0;
      for (int i = 0; i < 120; i++) begin
         if (cycleDone) begin cdCount++; cdIdx = i; end
         if (m3cntFirst1) f1Count++;
         if (m3cntLast2) l2Count++;
         if (i == 47) begin
            checkOutput("midStep", 32'(sgStep), 32'd4);
            checkOutput("midCnt", 32'(m3cnt), 32'd7);
         end
         tick();
      end
      checkOutput("cycleDoneCount", 32'(cdCount), 32'd1);
      checkOutput("cycleDoneIdx", 32'(cdIdx), 32'd119);
      checkOutput("first1Count", 32'(f1Count), 32'd12);
      checkOutput("last2Count", 32'(l2Count), 32'd12);

      // Length change mid-step 3 only affects step 4 onward.
      repeat (35) tick();
      checkOutput("chgStep", 32'(sgStep), 32'd3);
      checkOutput("chgCnt", 32'(m3cnt), 32'd5);
      applyStimulus(1'b1, 1'b0, 25'd20);
      repeat (4) tick();
      checkOutput("step3Last", 32'(m3cntLast1), 32'd1);
      tick();
      checkOutput("step4Start", 32'(sgStep), 32'd4);
      repeat (19) tick();
      checkOutput("step4Cnt19", 32'(m3cnt), 32'd19);
      checkOutput("step4Last1", 32'(m3cntLast1), 32'd1);
      tick();
      checkOutput("step5Start", 32'(sgStep), 32'd5);

      // Orderly stop: step 5 keeps 20 clocks, steps 6..11 take 4 each.
      applyStimulus(1'b0, 1'b0, 25'd4);
      pwmLow = 0;
      for (int k = 0; k < 44; k++) begin
         if (!pwmActive1) pwmLow++;
         if (k == 43) begin
            checkOutput("stopLastStep", 32'(sgStep), 32'd11);
            checkOutput("stopLastCnt", 32'(m3cnt), 32'd3);
         end
         tick();
      end
      checkOutput("stopPwmGap", 32'(pwmLow), 32'd0);
      checkOutput("stopPwm", 32'(pwmActive1), 32'd0);
      checkOutput("stopStep", 32'(sgStep), 32'd15);
      checkOutput("stopBusy", 32'(busy), 32'd0);

      // Clamp: a request of 2 runs as 4-clock steps.
      applyStimulus(1'b1, 1'b0, 25'd2);
      repeat (2) tick();
      repeat (2) tick();
      checkOutput("clampLast2", 32'(m3cntLast2), 32'd1);
      tick();
      checkOutput("clampLast1", 32'(m3cntLast1), 32'd1);
      checkOutput("clampCnt", 32'(m3cnt), 32'd3);
      tick();
      checkOutput("clampStep1", 32'(sgStep), 32'd1);

      // runEn returns during STOP: no gap in the sequence.
      applyStimulus(1'b0, 1'b0, 25'd2);
      repeat (24) tick();
      checkOutput("resumeStep", 32'(sgStep), 32'd7);
      applyStimulus(1'b1, 1'b0, 25'd2);
      pwmLow = 0;
      repeat (24) begin
         tick();
         if (!pwmActive1) pwmLow++;
      end
      checkOutput("resumeGap", 32'(pwmLow), 32'd0);
      checkOutput("resumeWrap", 32'(sgStep), 32'd1);

      // Fault at step 6, count 3.
      applyStimulus(1'b1, 1'b0, 25'd10);
      repeat (47) tick();
      checkOutput("preFaultStep", 32'(sgStep), 32'd6);
      checkOutput("preFaultCnt", 32'(m3cnt), 32'd3);
      applyStimulus(1'b1, 1'b1, 25'd10);
      tick();
      checkOutput("faultPwm", 32'(pwmActive1), 32'd0);
      checkOutput("faultStep", 32'(sgStep), 32'd15);
      checkOutput("faultFlagSet", 32'(faultFlag), 32'd1);
      applyStimulus(1'b1, 1'b0, 25'd10);
      repeat (3) tick();
      checkOutput("faultHold", 32'(faultFlag), 32'd1);
      checkOutput("faultNoRestart", 32'(busy), 32'd0);
      applyStimulus(1'b0, 1'b0, 25'd10);
      tick();
      checkOutput("faultClear", 32'(faultFlag), 32'd0);

      // Asynchronous reset in step 2, then restart through ARM.
      applyStimulus(1'b1, 1'b0, 25'd10);
      repeat (2) tick();
      repeat (25) tick();
      checkOutput("preRstStep", 32'(sgStep), 32'd2);
      checkOutput("preRstCnt", 32'(m3cnt), 32'd5);
      #1 nRst = 1'b0;
      #1;
      checkOutput("rstStep", 32'(sgStep), 32'd15);
      checkOutput("rstCnt", 32'(m3cnt), 32'd0);
      checkOutput("rstPwm", 32'(pwmActive1), 32'd0);
      tick();
      nRst = 1'b1;
      tick();
      checkOutput("rearmBusy", 32'(busy), 32'd1);
      checkOutput("rearmPwm", 32'(pwmActive1), 32'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 49) == 0) runEn = ~runEn;
         if (!faultIn && $urandom_range(0, 299) == 0) faultIn = 1'b1;
         else if (faultIn && $urandom_range(0, 3) == 0) faultIn = 1'b0;
         if ($urandom_range(0, 29) == 0) m3r_stepLen = 25'($urandom_range(0, 9));
         if ($urandom_range(0, 799) == 0) begin
            #1 nRst = 1'b0;
            tick();
            nRst = 1'b1;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
